uart_autobaud_tx: RTL and testbench

- Transmit end of the auto-baud serial link: serialises bytes onto uxtx_ so the receive-side baud-rate generator / auto-baud circuit can lock onto and sample them.
- One-entry holding buffer plus shift register; bit timing from an internal down-counter reloaded from div_.
- Dedicated sync request sends the 0x55 auto-baud calibration character (alternating 0/1 edges).
- Raises a completion flag per frame, mirroring the receiver's uxrxif_.

---
 rtl/uart_autobaud_tx.sv | 142 ++++++++++++++
 tb/tb_uart_autobaud_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_tx.sv
`timescale 1ns/1ps
// uart_autobaud_tx: single-buffered UART transmitter; sync_ queues the 0x55 auto-baud character.
// Define UART_AUTOBAUD_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_autobaud_tx #(
    parameter int DIV_W     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             clk_,
    input  logic             rst_,
    input  logic             txen_,
    input  logic             wr_,
    input  logic [7:0]       din_,
    input  logic             sync_,
    input  logic [DIV_W-1:0] div_,
    input  logic             clrovr_,
    output logic             uxtx_,
    output logic             txbf_,
    output logic             trmt_,
    output logic             uxtxif_,
    output logic             ovrn_
);

`ifdef UART_AUTOBAUD_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       hold_q, shf_q;
    logic             txbf_q, ovrn_q;
    logic [DIV_W-1:0] divl_q, cnt_q;
    logic [2:0]       bitidx_q;
    logic             stopidx_q;
    logic             bit_end, last_stop, load;
`ifdef UART_AUTOBAUD_TX_PARITY_EN
    logic             par_q;
`endif

    // cnt_q counts div..0, so each bit lasts div+1 clocks with no reload gap
    assign bit_end   = (cnt_q == '0);
    assign last_stop = (state_q == STOP) && bit_end && (stopidx_q == 1'(STOP_BITS - 1));
    assign load      = txen_ && txbf_q && ((state_q == IDLE) || last_stop);

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (load) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && bitidx_q == 3'd7) begin
`ifdef UART_AUTOBAUD_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_AUTOBAUD_TX_PARITY_EN
            PAR:   if (bit_end) state_d = STOP;
`endif
            STOP:  if (last_stop) state_d = load ? START : IDLE;
            default: state_d = IDLE;
        endcase
        // Dropping the enable abandons the frame on the next edge
        if (!txen_) state_d = IDLE;
    end

    always_comb begin
        uxtx_ = 1'b1;
        case (state_q)
            START: uxtx_ = 1'b0;
            DATA:  uxtx_ = shf_q[0];
`ifdef UART_AUTOBAUD_TX_PARITY_EN
            PAR:   uxtx_ = par_q;
`endif
            default: uxtx_ = 1'b1;
        endcase
    end

    assign trmt_   = (state_q == IDLE);
    assign uxtxif_ = last_stop && txen_;
    assign txbf_   = txbf_q;
    assign ovrn_   = ovrn_q;

    // Holding buffer and overrun flag; load implies txbf_q=1, so a write never races a transfer
    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            hold_q <= '0;
            txbf_q <= 1'b0;
            ovrn_q <= 1'b0;
        end else begin
            if (!txbf_q && wr_)        hold_q <= din_;
            else if (!txbf_q && sync_) hold_q <= 8'h55;

            if (load)                          txbf_q <= 1'b0;
            else if (!txbf_q && (wr_ || sync_)) txbf_q <= 1'b1;

            if (txbf_q && (wr_ || sync_)) ovrn_q <= 1'b1;
            else if (clrovr_)            ovrn_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            shf_q     <= '0;
            divl_q    <= '0;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            stopidx_q <= 1'b0;
`ifdef UART_AUTOBAUD_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (load) begin
            shf_q     <= hold_q;
            divl_q    <= div_;
            cnt_q     <= div_;
            bitidx_q  <= '0;
            stopidx_q <= 1'b0;
`ifdef UART_AUTOBAUD_TX_PARITY_EN
            par_q     <= ^hold_q;
`endif
        end else if (state_q != IDLE && txen_) begin
            if (bit_end) begin
                cnt_q <= divl_q;
                if (state_q == DATA) begin
                    shf_q    <= {1'b0, shf_q[7:1]};
                    bitidx_q <= bitidx_q + 3'd1;
                end
                if (state_q == STOP) stopidx_q <= stopidx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_tx.sv
`timescale 1ns/1ps
// Directed bench for uart_autobaud_tx: frame timing, sync char, back-to-back, overrun, abort, reset, stop bits.
module tb_uart_autobaud_tx;

`ifdef UART_AUTOBAUD_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 10 + PB;   // bits per frame with one stop bit

    logic       clk_ = 1'b0;
    logic       rst_, txen_, wr_, sync_, clrovr_;
    logic [7:0] din_, div_;
    logic       uxtx_, txbf_, trmt_, uxtxif_, ovrn_;
    logic       uxtx2, txbf2, trmt2, uxtxif2, ovrn2;

    int ncmp = 0;
    int nerr = 0;

    uart_autobaud_tx #(.DIV_W(8), .STOP_BITS(1)) u_dut (
        .clk_(clk_), .rst_(rst_), .txen_(txen_), .wr_(wr_), .din_(din_), .sync_(sync_),
        .div_(div_), .clrovr_(clrovr_), .uxtx_(uxtx_), .txbf_(txbf_), .trmt_(trmt_),
        .uxtxif_(uxtxif_), .ovrn_(ovrn_)
    );

    uart_autobaud_tx #(.DIV_W(8), .STOP_BITS(2)) u_dut2 (
        .clk_(clk_), .rst_(rst_), .txen_(txen_), .wr_(wr_), .din_(din_), .sync_(sync_),
        .div_(div_), .clrovr_(clrovr_), .uxtx_(uxtx2), .txbf_(txbf2), .trmt_(trmt2),
        .uxtxif_(uxtxif2), .ovrn_(ovrn2)
    );

    always #5 clk_ = ~clk_;

    // Frame bits in line order: bit 0 = start, then data LSB first, [parity], stop(s)
    function automatic logic [11:0] mkframe(input logic [7:0] d);
`ifdef UART_AUTOBAUD_TX_PARITY_EN
        return {2'b11, ^d, d, 1'b0};
`else
        return {3'b111, d, 1'b0};
`endif
    endfunction

    task automatic test_reset();
        rst_ = 1'b0; txen_ = 1'b0; wr_ = 1'b0; sync_ = 1'b0; clrovr_ = 1'b0;
        din_ = 8'h00; div_ = 8'd0;
        repeat (3) @(posedge clk_);
        #1;
        ncmp++; if (uxtx_ !== 1'b1)   begin nerr++; $display("FAIL reset_uxtx got %b want 1", uxtx_); end
        ncmp++; if (txbf_ !== 1'b0)   begin nerr++; $display("FAIL reset_txbf got %b want 0", txbf_); end
        ncmp++; if (trmt_ !== 1'b1)   begin nerr++; $display("FAIL reset_trmt got %b want 1", trmt_); end
        ncmp++; if (uxtxif_ !== 1'b0) begin nerr++; $display("FAIL reset_uxtxif got %b want 0", uxtxif_); end
        ncmp++; if (ovrn_ !== 1'b0)   begin nerr++; $display("FAIL reset_ovrn got %b want 0", ovrn_); end
        ncmp++; if (uxtx2 !== 1'b1 || trmt2 !== 1'b1) begin
            nerr++; $display("FAIL reset_dut2 got uxtx=%b trmt=%b want 1/1", uxtx2, trmt2);
        end
        @(negedge clk_); rst_ = 1'b1;
        @(posedge clk_); #1;
    endtask

    // div_=3, 0xA5; div_ is disturbed mid-frame and must not affect the running frame
    task automatic test_frame();
        logic [11:0] fr;
        logic e;
        fr = mkframe(8'hA5);
        div_ = 8'd3; txen_ = 1'b1; din_ = 8'hA5; wr_ = 1'b1;
        @(posedge clk_); #1;
        wr_ = 1'b0;
        ncmp++; if (txbf_ !== 1'b1 || uxtx_ !== 1'b1) begin
            nerr++; $display("FAIL frame_load got txbf=%b uxtx=%b want 1/1", txbf_, uxtx_);
        end
        for (int k = 0; k <= NB*4; k++) begin
            if (k == 5) div_ = 8'd0;
            @(posedge clk_); #1;
            e = (k < NB*4) ? fr[k/4] : 1'b1;
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL frame_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (uxtxif_ !== (k == NB*4-1)) begin
                nerr++; $display("FAIL frame_uxtxif k=%0d got %b want %b", k, uxtxif_, (k == NB*4-1));
            end
            ncmp++; if (trmt_ !== (k == NB*4)) begin
                nerr++; $display("FAIL frame_trmt k=%0d got %b want %b", k, trmt_, (k == NB*4));
            end
            if (k == 0) begin
                ncmp++; if (txbf_ !== 1'b0) begin nerr++; $display("FAIL frame_txbf_clr got %b want 0", txbf_); end
            end
        end
    endtask

    // Sync character at div_=0: one clock per bit, alternating line
    task automatic test_sync();
        logic [11:0] fr;
        logic e;
        fr = mkframe(8'h55);
        div_ = 8'd0; sync_ = 1'b1;
        @(posedge clk_); #1;
        sync_ = 1'b0;
        for (int k = 0; k < NB + 2; k++) begin
            @(posedge clk_); #1;
            e = (k < NB) ? fr[k] : 1'b1;
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL sync_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (uxtxif_ !== (k == NB-1)) begin
                nerr++; $display("FAIL sync_uxtxif k=%0d got %b want %b", k, uxtxif_, (k == NB-1));
            end
        end
    endtask

    // 0x00 then 0xFF queued behind it; overrun set/clear and set-beats-clear
    task automatic test_back_to_back();
        logic [11:0] f0, f1;
        logic e, eo, eb;
        f0 = mkframe(8'h00);
        f1 = mkframe(8'hFF);
        div_ = 8'd1; din_ = 8'h00; wr_ = 1'b1;
        @(posedge clk_); #1;
        wr_ = 1'b0;
        for (int k = 0; k <= 4*NB; k++) begin
            wr_ = 1'b0; clrovr_ = 1'b0;
            if (k == 1) begin wr_ = 1'b1; din_ = 8'hFF; end
            if (k == 2) begin wr_ = 1'b1; din_ = 8'h12; end
            if (k == 3) clrovr_ = 1'b1;
            if (k == 4) begin wr_ = 1'b1; din_ = 8'h34; clrovr_ = 1'b1; end
            if (k == 5) clrovr_ = 1'b1;
            @(posedge clk_); #1;
            wr_ = 1'b0; clrovr_ = 1'b0;
            if (k < 2*NB)      e = f0[k/2];
            else if (k < 4*NB) e = f1[(k-2*NB)/2];
            else               e = 1'b1;
            eo = (k == 2 || k == 4);
            eb = (k >= 1 && k < 2*NB);
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL b2b_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (uxtxif_ !== (k == 2*NB-1 || k == 4*NB-1)) begin
                nerr++; $display("FAIL b2b_uxtxif k=%0d got %b", k, uxtxif_);
            end
            ncmp++; if (trmt_ !== (k == 4*NB)) begin nerr++; $display("FAIL b2b_trmt k=%0d got %b", k, trmt_); end
            if (k < 8) begin
                ncmp++; if (ovrn_ !== eo) begin nerr++; $display("FAIL b2b_ovrn k=%0d got %b want %b", k, ovrn_, eo); end
            end
            ncmp++; if (txbf_ !== eb) begin nerr++; $display("FAIL b2b_txbf k=%0d got %b want %b", k, txbf_, eb); end
        end
    endtask

    // wr_ beats sync_; txen_ dropped after 12 clocks; queued 0x81 goes out when txen_ returns
    task automatic test_abort();
        logic [11:0] fa, fb;
        logic e;
        fa = mkframe(8'h3C);
        fb = mkframe(8'h81);
        div_ = 8'd2; txen_ = 1'b1; din_ = 8'h3C; wr_ = 1'b1; sync_ = 1'b1;
        @(posedge clk_); #1;
        wr_ = 1'b0; sync_ = 1'b0;
        ncmp++; if (ovrn_ !== 1'b0 || txbf_ !== 1'b1) begin
            nerr++; $display("FAIL abort_wrsync got ovrn=%b txbf=%b want 0/1", ovrn_, txbf_);
        end
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin wr_ = 1'b1; din_ = 8'h81; end
            if (k == 12) txen_ = 1'b0;
            @(posedge clk_); #1;
            wr_ = 1'b0;
            e = (k < 12) ? fa[k/3] : 1'b1;
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL abort_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (trmt_ !== (k >= 12)) begin nerr++; $display("FAIL abort_trmt k=%0d got %b", k, trmt_); end
            ncmp++; if (uxtxif_ !== 1'b0) begin nerr++; $display("FAIL abort_uxtxif k=%0d got %b want 0", k, uxtxif_); end
            if (k >= 1) begin
                ncmp++; if (txbf_ !== 1'b1) begin nerr++; $display("FAIL abort_txbf k=%0d got %b want 1", k, txbf_); end
            end
        end
        txen_ = 1'b1;
        for (int k = 0; k <= NB*3; k++) begin
            @(posedge clk_); #1;
            e = (k < NB*3) ? fb[k/3] : 1'b1;
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL resume_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (uxtxif_ !== (k == NB*3-1)) begin nerr++; $display("FAIL resume_uxtxif k=%0d got %b", k, uxtxif_); end
            ncmp++; if (trmt_ !== (k == NB*3)) begin nerr++; $display("FAIL resume_trmt k=%0d got %b", k, trmt_); end
        end
    endtask

    // Asynchronous reset in the middle of a start bit with a full buffer and overrun pending
    task automatic test_reset_mid();
        div_ = 8'd2; sync_ = 1'b1;
        @(posedge clk_); #1;
        sync_ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin wr_ = 1'b1; din_ = 8'h11; end
            if (k == 2) begin wr_ = 1'b1; din_ = 8'h22; end
            @(posedge clk_); #1;
            wr_ = 1'b0;
        end
        ncmp++; if (uxtx_ !== 1'b0 || txbf_ !== 1'b1 || ovrn_ !== 1'b1 || trmt_ !== 1'b0) begin
            nerr++; $display("FAIL rstmid_pre got uxtx=%b txbf=%b ovrn=%b trmt=%b want 0/1/1/0", uxtx_, txbf_, ovrn_, trmt_);
        end
        #2 rst_ = 1'b0;
        #1;
        ncmp++; if (uxtx_ !== 1'b1)   begin nerr++; $display("FAIL rstmid_uxtx got %b want 1", uxtx_); end
        ncmp++; if (txbf_ !== 1'b0)   begin nerr++; $display("FAIL rstmid_txbf got %b want 0", txbf_); end
        ncmp++; if (trmt_ !== 1'b1)   begin nerr++; $display("FAIL rstmid_trmt got %b want 1", trmt_); end
        ncmp++; if (ovrn_ !== 1'b0)   begin nerr++; $display("FAIL rstmid_ovrn got %b want 0", ovrn_); end
        ncmp++; if (uxtxif_ !== 1'b0) begin nerr++; $display("FAIL rstmid_uxtxif got %b want 0", uxtxif_); end
        @(negedge clk_); rst_ = 1'b1;
        @(posedge clk_); #1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_); #1;
            ncmp++; if (uxtx_ !== 1'b1 || trmt_ !== 1'b1 || txbf_ !== 1'b0) begin
                nerr++; $display("FAIL rstmid_idle k=%0d got uxtx=%b trmt=%b txbf=%b", k, uxtx_, trmt_, txbf_);
            end
        end
    endtask

    // div_=1, 0x07 on both instances: one vs two stop bits
    task automatic test_stop2();
        logic [11:0] fr;
        logic e;
        fr = mkframe(8'h07);
        div_ = 8'd1; din_ = 8'h07; wr_ = 1'b1;
        @(posedge clk_); #1;
        wr_ = 1'b0;
        for (int k = 0; k <= (NB+1)*2; k++) begin
            @(posedge clk_); #1;
            e = (k < NB*2) ? fr[k/2] : 1'b1;
            ncmp++; if (uxtx2 !== e) begin nerr++; $display("FAIL stop2_uxtx k=%0d got %b want %b", k, uxtx2, e); end
            ncmp++; if (uxtx_ !== e) begin nerr++; $display("FAIL stop1_uxtx k=%0d got %b want %b", k, uxtx_, e); end
            ncmp++; if (uxtxif2 !== (k == (NB+1)*2-1)) begin nerr++; $display("FAIL stop2_uxtxif k=%0d got %b", k, uxtxif2); end
            ncmp++; if (trmt2 !== (k == (NB+1)*2)) begin nerr++; $display("FAIL stop2_trmt k=%0d got %b", k, trmt2); end
            ncmp++; if (uxtxif_ !== (k == NB*2-1)) begin nerr++; $display("FAIL stop1_uxtxif k=%0d got %b", k, uxtxif_); end
            ncmp++; if (trmt_ !== (k >= NB*2)) begin nerr++; $display("FAIL stop1_trmt k=%0d got %b", k, trmt_); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_sync();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_stop2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
